// File: rtl/fir_decim_if.sv
// Output sample stream of the fir_decim decimator: valid/ready handshake with a 16-bit signed
// payload.
interface fir_decim_if;
   logic               m_valid;
   logic               m_ready;
   logic signed [15:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fir_decim.sv
// Decimator after the FIR stage: keeps one of every DECIM samples (or the boxcar average of
// each group when FIR_DECIM_AVG_EN is defined), applies a saturating gain and queues in a FWFT FIFO.
module fir_decim #(
   parameter int unsigned DECIM      = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GAIN_SHIFT = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cke,
   input  logic signed [15:0]      din,
   input  logic                    phase_clr,
   fir_decim_if.master             m,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   input  logic                    ovf_clr
);

   localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
   // A phase_clr sample counts as phase 0, so the counter resumes at 1.
   localparam logic [CW-1:0] CNT_CLR  = (DECIM > 1) ? CW'(1) : '0;
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (phase_clr) begin
         cnt_d = cke ? CNT_CLR : '0;
      end else if (cke) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   logic               cand;
   logic signed [15:0] cand_val;

`ifdef FIR_DECIM_AVG_EN
   localparam int unsigned LG = $clog2(DECIM);
   localparam int unsigned SW = 16 + LG;

   logic signed [SW-1:0] acc_q, sum;

   always_comb begin
      sum = SW'(din);
      if (!phase_clr && (cnt_q != '0)) begin
         sum = acc_q + SW'(din);
      end
      cand     = cke && (phase_clr ? (DECIM == 1) : (cnt_q == CNT_LAST));
      cand_val = 16'(sum >>> LG);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
      end else if (cke) begin
         acc_q <= sum;
      end
   end
`else
   assign cand     = cke && (phase_clr || (cnt_q == '0));
   assign cand_val = din;
`endif

   logic signed [23:0] t;
   logic signed [15:0] gained;

   always_comb begin
      t = 24'(cand_val) <<< GAIN_SHIFT;
      if (t > 24'sd32767) begin
         gained = 16'sh7FFF;
      end else if (t < -24'sd32768) begin
         gained = 16'sh8000;
      end else begin
         gained = t[15:0];
      end
   end

   logic signed [15:0] mem_q [DEPTH];
   logic [AW-1:0]      wptr_q, rptr_q, rnext;
   logic [AW:0]        count_q, count_d;
   logic signed [15:0] head_q, head_d;
   logic               ovf_q;
   logic               pop, full, push, drop;

   always_comb begin
      pop   = (count_q != '0) && m.m_ready;
      full  = (count_q == CNT_FULL);
      push  = cand && (!full || pop);
      drop  = cand && full && !pop;
      rnext = rptr_q + 1'b1;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Head register tracks the entry at rptr so m_data stays a flop output.
      head_d = head_q;
      if (pop && (count_q > CNT_ONE)) begin
         head_d = mem_q[rnext];
      end else if (push && ((count_q == '0) || (pop && (count_q == CNT_ONE)))) begin
         head_d = gained;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= gained;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         head_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rnext;
         end
         count_q <= count_d;
         head_q  <= head_d;
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign m.m_valid = (count_q != '0);
   assign m.m_data  = head_q;
   assign level     = count_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_decim.sv
// Randomised and directed bench for fir_decim against a sample-queue reference model; a second
// instance (DECIM=1, GAIN_SHIFT=2) exercises gain saturation.
module tb_fir_decim;

   localparam int DECIM = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rstn;
   logic cke, phase_clr, ovf_clr, ovf;
   logic signed [15:0] din;
   logic [2:0] level;

   logic cke2, ovf2;
   logic signed [15:0] din2;
   logic [1:0] level2;

   fir_decim_if bus();
   fir_decim_if bus2();

   always #5 clk = ~clk;

   fir_decim #(.DECIM(DECIM), .DEPTH(DEPTH), .GAIN_SHIFT(0)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .cke       (cke),
      .din       (din),
      .phase_clr (phase_clr),
      .m         (bus),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   fir_decim #(.DECIM(1), .DEPTH(2), .GAIN_SHIFT(2)) u_dut_gain (
      .clk       (clk),
      .rstn      (rstn),
      .cke       (cke2),
      .din       (din2),
      .phase_clr (1'b0),
      .m         (bus2),
      .level     (level2),
      .ovf       (ovf2),
      .ovf_clr   (1'b0)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: queue of pending output samples plus position within the current group.
   int q[$];
   bit m_ovf;
   int k;
   int grp_sum;

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf   = 1'b0;
      k       = 0;
      grp_sum = 0;
   endtask

   task automatic model_edge(input bit c, input int d, input bit pc, input bit r, input bit oc);
      bit popm, candm, fullm, dropm;
      int val;
      popm  = (q.size() != 0) && r;
      fullm = (q.size() == DEPTH);
      candm = 1'b0;
      val   = 0;
      if (pc) k = 0;
      if (c) begin
`ifdef FIR_DECIM_AVG_EN
         if (k == 0) grp_sum = 0;
         grp_sum += d;
         if (k == DECIM - 1) begin
            candm = 1'b1;
            val   = int'($floor(real'(grp_sum) / real'(DECIM)));
         end
`else
         if (k == 0) begin
            candm = 1'b1;
            val   = d;
         end
`endif
         k = (k + 1) % DECIM;
      end
      if (popm) void'(q.pop_front());
      dropm = candm && fullm && !popm;
      if (candm && !dropm) q.push_back(sat16(val));
      if (dropm) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
   endtask

   task automatic compare();
      check("valid", int'(bus.m_valid), int'(q.size() != 0));
      check("level", int'(level), q.size());
      check("ovf", int'(ovf), int'(m_ovf));
      if (q.size() != 0) check("data", int'($signed(bus.m_data)), q[0]);
   endtask

   // Called just after a falling edge: drive, advance the model, check at the next falling edge.
   task automatic step(input logic c, input logic [15:0] d, input logic pc, input logic r,
                       input logic oc);
      cke         = c;
      din         = d;
      phase_clr   = pc;
      bus.m_ready = r;
      ovf_clr     = oc;
      model_edge(c, int'($signed(d)), pc, r, oc);
      @(negedge clk);
      compare();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic step_gain(input logic [15:0] d);
      cke2 = 1'b1;
      din2 = d;
      @(negedge clk);
      check("gain_valid", int'(bus2.m_valid), 1);
      check("gain_data", int'($signed(bus2.m_data)), sat16(int'($signed(d)) * 4));
   endtask

   initial begin
      int outs[$];
      int exp4[5] = '{0, 4, 5, 9, 13};
      int thr;

      rstn         = 1'b0;
      cke          = 1'b0;
      din          = '0;
      phase_clr    = 1'b0;
      ovf_clr      = 1'b0;
      bus.m_ready  = 1'b0;
      cke2         = 1'b0;
      din2         = '0;
      bus2.m_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rstn = 1'b1;
      @(negedge clk);

      // Gain saturation on the DECIM=1 instance, then a few random samples.
      step_gain(16'sh3000);
      check("gain_pos_sat", int'($signed(bus2.m_data)), 32767);
      step_gain(-16'sd100);
      check("gain_neg", int'($signed(bus2.m_data)), -400);
      step_gain(-16'sh4000);
      check("gain_neg_sat", int'($signed(bus2.m_data)), -32768);
      for (int i = 0; i < 8; i++) step_gain(16'($urandom));
      cke2 = 1'b0;
      @(negedge clk);

      // Asynchronous reset with three samples queued.
      step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
`ifndef FIR_DECIM_AVG_EN
      check("pre_reset_level", int'(level), 3);
`endif
      #2 rstn = 1'b0;
      cke = 1'b0;
      #1;
      check("rst_valid", int'(bus.m_valid), 0);
      check("rst_data", int'($signed(bus.m_data)), 0);
      check("rst_level", int'(level), 0);
      check("rst_ovf", int'(ovf), 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

`ifndef FIR_DECIM_AVG_EN
      // Pick every fourth sample with a ready sink.
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
         check("t2_level_le1", int'(level <= 3'd1), 1);
         if (i % 4 == 0) check("t2_data", int'($signed(bus.m_data)), i);
      end

      // Fill with a stalled sink, overflow, then drain and clear.
      drain();
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
         if (i == 12) check("t3_level_full", int'(level), 4);
      end
      check("t3_ovf_set", int'(ovf), 1);
      for (int j = 0; j < 4; j++) begin
         check("t3_drain", int'($signed(bus.m_data)), 4 * j);
         step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      end
      check("t3_empty", int'(bus.m_valid), 0);
      check("t3_ovf_held", int'(ovf), 1);
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("t3_ovf_clr", int'(ovf), 0);

      // phase_clr with cke at din=5; din=4 is still a phase-0 sample.
      drain();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'(i), 1'(i == 5), 1'b1, 1'b0);
         if (bus.m_valid) outs.push_back(int'($signed(bus.m_data)));
      end
      check("t4_count", outs.size(), 5);
      for (int i = 0; i < 5 && i < outs.size(); i++) check("t4_data", outs[i], exp4[i]);
`else
      drain();
      step(1'b1, 16'sd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'sd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'sd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'sd6, 1'b0, 1'b0, 1'b0);
      check("avg_pos", int'($signed(bus.m_data)), 3);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, -16'sd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, -16'sd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, -16'sd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, -16'sd2, 1'b0, 1'b0, 1'b0);
      check("avg_neg", int'($signed(bus.m_data)), -2);
`endif

      // Random traffic; sink readiness varies per segment so the FIFO both fills and empties.
      drain();
      for (int seg = 0; seg < 8; seg++) begin
         thr = 10 + 25 * (seg % 4);
         for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 99) < thr), 1'($urandom_range(0, 15) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
